// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the instruction fetch path: widths, opcode
// groups, control sub-opcodes and the fetch FSM state encoding.
package cpu_isa_pkg;

  localparam int IR_W = 24;
  localparam int PC_W = 12;

  localparam logic [3:0]  GRP_CTRL = 4'h1;
  localparam logic [23:0] GRP_MISC = 24'h080000;
  localparam logic [23:0] RET_MISC = 24'h080005;

  localparam logic [7:0] OP_JMP = 8'h00;
  localparam logic [7:0] OP_JZE = 8'h01;
  localparam logic [7:0] OP_JNE = 8'h02;
  localparam logic [7:0] OP_JCY = 8'h03;
  localparam logic [7:0] OP_RET = 8'h04;
  localparam logic [7:0] OP_BSR = 8'h05;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_RESOLVE
  } ifu_state_t;

  // Conditional branches are the only instructions that depend on ALU flags.
  function automatic logic is_cond_branch(input logic [23:0] w);
    return (w[23:20] == GRP_CTRL) &&
           ((w[19:12] == OP_JZE) || (w[19:12] == OP_JNE) || (w[19:12] == OP_JCY));
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Program-memory and decoder-side signals of the fetch unit, bundled so the
// unit and its environment see one port; master is the fetch unit side.
interface instr_fetch_unit_if #(
  parameter int PC_W = cpu_isa_pkg::PC_W,
  parameter int IR_W = cpu_isa_pkg::IR_W
);
  logic [PC_W-1:0] pmem_addr;
  logic            pmem_rd;
  logic [IR_W-1:0] pmem_rdata;
  logic [IR_W-1:0] ir;
  logic            ir_valid;
  logic            ir_ready;
  logic            flag_z;
  logic            flag_cy;
  logic            flags_valid;
  logic [PC_W-1:0] pc;

  modport master (
    output pmem_addr, pmem_rd, ir, ir_valid, pc,
    input  pmem_rdata, ir_ready, flag_z, flag_cy, flags_valid
  );

  modport slave (
    input  pmem_addr, pmem_rd, ir, ir_valid, pc,
    output pmem_rdata, ir_ready, flag_z, flag_cy, flags_valid
  );
endinterface

// File: rtl/ifu_call_stack.sv
// Hardware return-address stack; overflowing pushes and underflowing pops are
// ignored and flagged with a one-cycle err pulse.
module ifu_call_stack #(
  parameter int STACK_DEPTH = 8,
  parameter int PC_W        = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty,
  output logic            err
);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [PC_W-1:0]  mem [STACK_DEPTH];
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx = sp[IDX_W-1:0];
  assign rd_idx = wr_idx - IDX_W'(1);
  assign full   = (sp == SP_FULL);
  assign empty  = (sp == '0);
  assign top    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp  <= '0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      if (push && !pop) begin
        if (full) err <= 1'b1;
        else      sp  <= sp + SP_W'(1);
      end else if (pop && !push) begin
        if (empty) err <= 1'b1;
        else       sp  <= sp - SP_W'(1);
      end
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches from synchronous program memory, hands words
// to the decoder and resolves control flow locally. IFU_ISSUE_CNT_EN adds issue_cnt.
module instr_fetch_unit #(
  parameter int PC_W        = cpu_isa_pkg::PC_W,
  parameter int IR_W        = cpu_isa_pkg::IR_W,
  parameter int STACK_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus,
  output logic                stack_err
`ifdef IFU_ISSUE_CNT_EN
  ,
  output logic [15:0]         issue_cnt
`endif
);
  import cpu_isa_pkg::*;

  ifu_state_t      state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] pmem_addr_q;
  logic [PC_W-1:0] pc_out_q;
  logic [PC_W-1:0] stk_top;
  logic [IR_W-1:0] ir_q;
  logic [7:0]      op;
  logic            is_ctrl;
  logic            pmem_rd_q;
  logic            ir_valid_q;
  logic            do_push;
  logic            do_pop;
  logic            cond_wait;
  logic            advance;
  logic            stk_full;
  logic            stk_empty;
  logic            stk_err;
  logic            unused_stk_full;

  assign bus.pmem_addr   = pmem_addr_q;
  assign bus.pmem_rd     = pmem_rd_q;
  assign bus.ir          = ir_q;
  assign bus.ir_valid    = ir_valid_q;
  assign bus.pc          = pc_out_q;
  assign unused_stk_full = stk_full;

  // Next-PC selection for the instruction held in ir; flags come straight from
  // the bus because they are only consumed on a cycle where flags_valid is high.
  always_comb begin
    is_ctrl = (ir_q[IR_W-1 -: 4] == GRP_CTRL);
    op      = ir_q[IR_W-5 -: 8];
    tgt     = ir_q[PC_W-1:0];
    pc_inc  = pc_q + PC_W'(1);
    next_pc = pc_inc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (is_ctrl) begin
      case (op)
        OP_JMP:  next_pc = tgt;
        OP_JZE:  next_pc = bus.flag_z  ? tgt : pc_inc;
        OP_JNE:  next_pc = !bus.flag_z ? tgt : pc_inc;
        OP_JCY:  next_pc = bus.flag_cy ? tgt : pc_inc;
        OP_RET:  do_pop  = 1'b1;
        OP_BSR: begin
          do_push = 1'b1;
          next_pc = tgt;
        end
        default: next_pc = pc_inc;
      endcase
    end else if (ir_q == RET_MISC) begin
      do_pop = 1'b1;
    end
    if (do_pop) begin
      next_pc = stk_empty ? '0 : stk_top;
    end
    cond_wait = is_cond_branch(ir_q) && !bus.flags_valid;
    advance   = ((state == ST_ISSUE) && bus.ir_ready && !cond_wait) ||
                ((state == ST_RESOLVE) && bus.flags_valid);
  end

  ifu_call_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .PC_W        (PC_W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (advance && do_push),
    .pop       (advance && do_pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .err       (stk_err)
  );

  // Read strobe is registered, so FETCH first arms pmem_rd (only needed right
  // after reset) and every later entry into FETCH arrives with it already set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc_q        <= '0;
      pmem_addr_q <= '0;
      pmem_rd_q   <= 1'b0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      pc_out_q    <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (pmem_rd_q) begin
            pmem_rd_q <= 1'b0;
            state     <= ST_WAIT;
          end else begin
            pmem_rd_q   <= 1'b1;
            pmem_addr_q <= pc_q;
          end
        end
        ST_WAIT: begin
          ir_q       <= bus.pmem_rdata;
          ir_valid_q <= 1'b1;
          pc_out_q   <= pc_q;
          state      <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (bus.ir_ready) begin
            ir_valid_q <= 1'b0;
            if (advance) begin
              pc_q        <= next_pc;
              pmem_addr_q <= next_pc;
              pmem_rd_q   <= 1'b1;
              state       <= ST_FETCH;
            end else begin
              state <= ST_RESOLVE;
            end
          end
        end
        ST_RESOLVE: begin
          if (advance) begin
            pc_q        <= next_pc;
            pmem_addr_q <= next_pc;
            pmem_rd_q   <= 1'b1;
            state       <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stack_err <= 1'b0;
    else     stack_err <= stack_err | stk_err;
  end

`ifdef IFU_ISSUE_CNT_EN
  logic [15:0] issue_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                            issue_cnt_q <= '0;
    else if (ir_valid_q && bus.ir_ready) issue_cnt_q <= issue_cnt_q + 16'd1;
  end

  assign issue_cnt = issue_cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a reference ISA walk predicts the
// (pc, ir) sequence handed to the decoder; the monitor compares each accept.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stack_err;
`ifdef IFU_ISSUE_CNT_EN
  logic [15:0] issue_cnt;
`endif

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stack_err (stack_err)
`ifdef IFU_ISSUE_CNT_EN
    ,
    .issue_cnt (issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [23:0] mem [4096];
  logic [35:0] exp_q [$];
  int          accept_times [$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          accept_cnt = 0;
  int          extra = 0;
  logic        exp_err;

  always @(posedge clk) cycle <= cycle + 1;

  // Synchronous program ROM: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.pmem_rd) bus.pmem_rdata <= mem[bus.pmem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every decoder accept pops one prediction.
  always @(negedge clk) begin
    logic [35:0] e;
    if (rst) begin
      accept_cnt = 0;
      extra      = 0;
      accept_times.delete();
    end else if (bus.ir_valid && bus.ir_ready) begin
      accept_cnt++;
      accept_times.push_back(cycle);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("issue_pc", 32'(bus.pc), 32'(e[35:24]));
        checkOutput("issue_ir", 32'(bus.ir), 32'(e[23:0]));
      end else begin
        extra++;
      end
    end
  end

  task automatic fill_default();
    for (int i = 0; i < 4096; i++) mem[i] = 24'h200000 | 24'(i);
  endtask

  // Reference walk of the program with fixed flags and an 8-entry stack.
  task automatic model_run(input int n, input logic fz, input logic fcy);
    logic [11:0] p, nxt, t;
    logic [11:0] stk [8];
    logic [23:0] w;
    int sp;
    p = 12'h000;
    sp = 0;
    exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      w = mem[p];
      t = w[11:0];
      exp_q.push_back({p, w});
      nxt = p + 12'h001;
      if (w[23:20] == 4'h1) begin
        case (w[19:12])
          8'h00: nxt = t;
          8'h01: if (fz)  nxt = t;
          8'h02: if (!fz) nxt = t;
          8'h03: if (fcy) nxt = t;
          8'h04: begin
            if (sp == 0) begin nxt = 12'h000; exp_err = 1'b1; end
            else begin sp--; nxt = stk[sp]; end
          end
          8'h05: begin
            if (sp == 8) exp_err = 1'b1;
            else begin stk[sp] = p + 12'h001; sp++; end
            nxt = t;
          end
          default: ;
        endcase
      end else if (w == 24'h080005) begin
        if (sp == 0) begin nxt = 12'h000; exp_err = 1'b1; end
        else begin sp--; nxt = stk[sp]; end
      end
      p = nxt;
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    bus.ir_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_pmem_rd",   32'(bus.pmem_rd),   32'd0);
    checkOutput("rst_pmem_addr", 32'(bus.pmem_addr), 32'd0);
    checkOutput("rst_ir",        32'(bus.ir),        32'd0);
    checkOutput("rst_ir_valid",  32'(bus.ir_valid),  32'd0);
    checkOutput("rst_pc",        32'(bus.pc),        32'd0);
    checkOutput("rst_stack_err", 32'(stack_err),     32'd0);
`ifdef IFU_ISSUE_CNT_EN
    checkOutput("rst_issue_cnt", 32'(issue_cnt),     32'd0);
`endif
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_accepts(input int n, input int budget);
    int cyc = 0;
    while (accept_cnt < n && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    if (accept_cnt < n) checkOutput("accept_timeout", 32'(accept_cnt), 32'(n));
  endtask

  task automatic finishRun(input string tag);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_stack_err"}, 32'(stack_err),    32'(exp_err));
    checkOutput({tag, "_pending"},   32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_extra"},     32'(extra),        32'd0);
`ifdef IFU_ISSUE_CNT_EN
    checkOutput({tag, "_issue_cnt"}, 32'(issue_cnt),    32'(accept_cnt));
`endif
  endtask

  task automatic applyStimulus(input string tag, input int n, input logic fz, input logic fcy);
    applyReset();
    bus.flag_z      = fz;
    bus.flag_cy     = fcy;
    bus.flags_valid = 1'b1;
    model_run(n, fz, fcy);
    bus.ir_ready = 1'b1;
    wait_accepts(n, 40 * n);
    #1 bus.ir_ready = 1'b0;
    finishRun(tag);
  endtask

  initial begin
    bus.ir_ready    = 1'b0;
    bus.flag_z      = 1'b0;
    bus.flag_cy     = 1'b0;
    bus.flags_valid = 1'b1;
    fill_default();

    // Straight-line code, back-to-back issue every 3 cycles.
    applyStimulus("seq", 5, 1'b0, 1'b0);
    checkOutput("seq_accepts", 32'(accept_times.size()), 32'd5);
    if (accept_times.size() >= 4) begin
      checkOutput("seq_interval_a", 32'(accept_times[2] - accept_times[1]), 32'd3);
      checkOutput("seq_interval_b", 32'(accept_times[3] - accept_times[2]), 32'd3);
    end

    // Reset in the middle of a running fetch stream.
    bus.ir_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 applyReset();

    mem[0] = 24'h100040;
    applyStimulus("jmp", 3, 1'b0, 1'b0);

    fill_default();
    mem[12'h000] = 24'h101080;
    mem[12'h080] = 24'h1020C0;
    mem[12'h081] = 24'h103200;
    mem[12'h201] = 24'h106123;
    mem[12'h202] = 24'h1FF000;
    applyStimulus("cond_set", 6, 1'b1, 1'b1);

    fill_default();
    mem[12'h000] = 24'h101080;
    mem[12'h001] = 24'h1020C0;
    mem[12'h0C0] = 24'h103300;
    applyStimulus("cond_clr", 4, 1'b0, 1'b0);

    // JZE accepted while flags are stale; stale flag_z=1 must not be used.
    fill_default();
    mem[12'h000] = 24'h101080;
    applyReset();
    bus.flags_valid = 1'b0;
    bus.flag_z      = 1'b1;
    bus.flag_cy     = 1'b0;
    model_run(3, 1'b0, 1'b0);
    bus.ir_ready = 1'b1;
    wait_accepts(1, 40);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("resolve_hold_rd",    32'(bus.pmem_rd),  32'd0);
      checkOutput("resolve_hold_valid", 32'(bus.ir_valid), 32'd0);
    end
    @(posedge clk);
    #1 bus.flags_valid = 1'b1;
    bus.flag_z = 1'b0;
    wait_accepts(3, 60);
    #1 bus.ir_ready = 1'b0;
    finishRun("resolve");

    // BSR/RET pair, then RET on the now-empty stack falls back to 0.
    fill_default();
    mem[12'h000] = 24'h100010;
    mem[12'h010] = 24'h105100;
    mem[12'h100] = 24'h104000;
    mem[12'h012] = 24'h080005;
    applyStimulus("call_ret", 6, 1'b0, 1'b0);

    fill_default();
    for (int i = 0; i < 9; i++) mem[i] = 24'h105000 | 24'(i + 1);
    applyStimulus("overflow", 10, 1'b0, 1'b0);

    fill_default();
    mem[12'h000] = 24'h100FFF;
    mem[12'hFFF] = 24'h2ABCDE;
    applyStimulus("wrap", 4, 1'b0, 1'b0);

    // Decoder stall: ir and ir_valid must hold while ir_ready is low.
    fill_default();
    applyReset();
    bus.flags_valid = 1'b1;
    model_run(2, 1'b0, 1'b0);
    begin
      int c = 0;
      while (!bus.ir_valid && c < 20) begin
        @(negedge clk);
        c++;
      end
    end
    checkOutput("hold_valid_rise", 32'(bus.ir_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_ir",    32'(bus.ir),       32'(mem[0]));
      checkOutput("hold_valid", 32'(bus.ir_valid), 32'd1);
      checkOutput("hold_pc",    32'(bus.pc),       32'd0);
    end
    @(posedge clk);
    #1 bus.ir_ready = 1'b1;
    wait_accepts(2, 40);
    #1 bus.ir_ready = 1'b0;
    finishRun("hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
